// File: rtl/result_burst_writer.sv
// result_burst_writer: packs 128-bit result words into 256-bit beats and writes them to SDRAM as Avalon-MM bursts.
module result_burst_writer #(
  parameter int BYTES_PER_ADDR = 32,
  parameter int BURST_N = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic         CLOCK,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  base_addr,
  input  logic [31:0]  total_bytes,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic [26:0]  sdram_address,
  output logic [7:0]   sdram_burstcount,
  output logic [255:0] sdram_writedata,
  output logic [31:0]  sdram_byteenable,
  output logic         sdram_write,
  input  logic         sdram_waitrequest,
  output logic         busy,
  output logic         done,
  output logic         overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] BPA = 32'(BYTES_PER_ADDR);
  localparam logic [31:0] BN = 32'(BURST_N);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, DONE} state_t;
  state_t state, state_nx;
  logic [26:0] addr, start_addr;
  logic [31:0] beats_left, pairs_left, start_beats, len;
  logic phase;
  logic [127:0] lo_word;
  logic [255:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [7:0] beat_cnt;
  logic active, accept_start, take, push, push_ok, pop, last_beat;

  assign active = state == WAIT_DATA || state == BURST;
  assign accept_start = start && state == IDLE;
  assign start_addr = 27'(base_addr / BPA);
  assign start_beats = total_bytes / BPA;
  assign len = beats_left < BN ? beats_left : BN;
  // pairs_left counts packed pairs (kept or dropped) so input stops after the job's worth
  assign take = in_valid && active && pairs_left != 0;
  assign push = take && phase;
  assign pop = state == BURST && !sdram_waitrequest;
  assign push_ok = push && (fifo_count != CW'(FIFO_DEPTH) || pop);
  assign last_beat = pop && beat_cnt == sdram_burstcount - 8'd1;

  always_ff @(posedge CLOCK or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept_start) state_nx = start_beats == 0 ? DONE : WAIT_DATA;
      WAIT_DATA: if (32'(fifo_count) >= len) state_nx = BURST;
      BURST: if (last_beat) state_nx = beats_left == len ? DONE : WAIT_DATA;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = active;
    done = state == DONE;
    sdram_write = state == BURST;
    sdram_byteenable = sdram_write ? '1 : '0;
    sdram_writedata = sdram_write ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge CLOCK)
    if (push_ok) mem[wr_ptr] <= {in_data, lo_word};

  always_ff @(posedge CLOCK or negedge reset_n)
    if (!reset_n) begin
      addr <= '0;
      beats_left <= '0;
      pairs_left <= '0;
      phase <= 1'b0;
      lo_word <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      sdram_address <= '0;
      sdram_burstcount <= '0;
      beat_cnt <= '0;
    end else if (accept_start) begin
      addr <= start_addr;
      beats_left <= start_beats;
      pairs_left <= start_beats;
      phase <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (take) phase <= !phase;
      if (take && !phase) lo_word <= in_data;
      if (push) pairs_left <= pairs_left - 32'd1;
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
      if (state == WAIT_DATA && state_nx == BURST) begin
        sdram_address <= addr;
        sdram_burstcount <= len[7:0];
        beat_cnt <= '0;
      end
      if (pop) beat_cnt <= beat_cnt + 8'd1;
      if (last_beat) begin
        addr <= addr + len[26:0];
        beats_left <= beats_left - len;
      end
    end
endmodule

// File: tb/tb_result_burst_writer.sv
// tb_result_burst_writer: directed scenario tests for result_burst_writer.
module tb_result_burst_writer;
  logic CLOCK = 0, reset_n = 0, start = 0, in_valid = 0, sdram_waitrequest = 0;
  logic [31:0] base_addr = 0, total_bytes = 0;
  logic [127:0] in_data = 0;
  logic [26:0] sdram_address;
  logic [7:0] sdram_burstcount;
  logic [255:0] sdram_writedata;
  logic [31:0] sdram_byteenable;
  logic sdram_write, busy, done, overflow;
  int checks = 0, errors = 0, wr_mode = 0;

  result_burst_writer dut (
    .CLOCK(CLOCK), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .total_bytes(total_bytes), .in_valid(in_valid), .in_data(in_data),
    .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount),
    .sdram_writedata(sdram_writedata), .sdram_byteenable(sdram_byteenable),
    .sdram_write(sdram_write), .sdram_waitrequest(sdram_waitrequest),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 CLOCK = ~CLOCK;

  // wr_mode: 0 never stall, 1 pseudo-random stall, 2 stall always
  always @(posedge CLOCK) begin
    #1;
    sdram_waitrequest = (wr_mode == 2) || (wr_mode == 1 && $urandom_range(0, 1) == 1);
  end

  logic [255:0] beat_q[$];
  logic [26:0] baddr_q[$];
  logic [7:0] bc_q[$];
  int done_cnt = 0, stall_err = 0;
  logic prev_write = 0, prev_stall = 0, prev_busy = 0, done_busy = 0, done_prev_busy = 0;
  logic [26:0] h_addr = 0;
  logic [7:0] h_bc = 0;
  logic [255:0] h_data = 0;

  always @(negedge CLOCK) begin
    if (reset_n && prev_stall && (!sdram_write || sdram_address !== h_addr ||
        sdram_burstcount !== h_bc || sdram_writedata !== h_data)) stall_err++;
    if (sdram_write && !prev_write) begin
      baddr_q.push_back(sdram_address);
      bc_q.push_back(sdram_burstcount);
    end
    if (sdram_write && !sdram_waitrequest) beat_q.push_back(sdram_writedata);
    if (done) begin
      done_cnt++;
      done_busy = busy;
      done_prev_busy = prev_busy;
    end
    prev_stall = reset_n && sdram_write && sdram_waitrequest;
    h_addr = sdram_address;
    h_bc = sdram_burstcount;
    h_data = sdram_writedata;
    prev_write = sdram_write;
    prev_busy = busy;
  end

  function automatic logic [127:0] word(input int tag, input int i);
    return {32'(tag), 32'(i), 32'h5A5A0000 + 32'(i), ~32'(i * 3)};
  endfunction

  function automatic logic [255:0] pair(input int tag, input int k);
    return {word(tag, 2 * k + 1), word(tag, 2 * k)};
  endfunction

  task automatic clear();
    beat_q.delete();
    baddr_q.delete();
    bc_q.delete();
    done_cnt = 0;
    stall_err = 0;
  endtask

  task automatic launch(input logic [31:0] ba, input logic [31:0] tb);
    @(posedge CLOCK); #1;
    base_addr = ba;
    total_bytes = tb;
    start = 1;
    @(posedge CLOCK); #1;
    start = 0;
  endtask

  task automatic feed(input int tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data = word(tag, first + i);
      @(posedge CLOCK); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge CLOCK); #2;
      n++;
    end
    repeat (3) @(negedge CLOCK);
    #2;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLOCK);
    checks++;
    if ({sdram_write, busy, done, overflow} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {sdram_write, busy, done, overflow});
    end
    checks++;
    if (sdram_address !== 27'd0 || sdram_burstcount !== 8'd0) begin
      errors++;
      $display("FAIL reset_addr_bc got %0h/%0h want 0/0", sdram_address, sdram_burstcount);
    end
    checks++;
    if (sdram_writedata !== 256'd0 || sdram_byteenable !== 32'd0) begin
      errors++;
      $display("FAIL reset_data_be got %0h/%0h want 0/0", sdram_writedata, sdram_byteenable);
    end
    @(posedge CLOCK); #1;
    reset_n = 1;
  endtask

  task automatic run_1k(input int tag, input int mode, input string nm);
    clear();
    wr_mode = mode;
    launch(32'h1000, 32'd1024);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", nm, busy); end
    feed(tag, 0, 64);
    wait_done(2000);
    wr_mode = 0;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s_done got %0d want 1", nm, done_cnt); end
    checks++;
    if (baddr_q.size() != 2) begin errors++; $display("FAIL %s_nbursts got %0d want 2", nm, baddr_q.size()); end
    else begin
      checks++;
      if (baddr_q[0] !== 27'h80 || bc_q[0] !== 8'd16) begin
        errors++; $display("FAIL %s_burst0 got %0h/%0d want 80/16", nm, baddr_q[0], bc_q[0]);
      end
      checks++;
      if (baddr_q[1] !== 27'h90 || bc_q[1] !== 8'd16) begin
        errors++; $display("FAIL %s_burst1 got %0h/%0d want 90/16", nm, baddr_q[1], bc_q[1]);
      end
    end
    checks++;
    if (beat_q.size() != 32) begin errors++; $display("FAIL %s_nbeats got %0d want 32", nm, beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 32; k++) begin
      checks++;
      if (beat_q[k] !== pair(tag, k)) begin
        errors++; $display("FAIL %s_beat%0d got %h want %h", nm, k, beat_q[k], pair(tag, k));
      end
    end
    checks++;
    if (done_busy !== 1'b0 || done_prev_busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy_fall got %b%b want 01", nm, done_busy, done_prev_busy);
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL %s_overflow got %b want 0", nm, overflow); end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL %s_stall_hold got %0d want 0", nm, stall_err); end
  endtask

  task automatic test_two_bursts();
    run_1k(1, 0, "two_bursts");
  endtask

  task automatic test_stall();
    run_1k(3, 1, "stall");
  endtask

  task automatic test_short();
    clear();
    launch(32'h40, 32'd96);
    feed(2, 0, 6);
    wait_done(200);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL short_done got %0d want 1", done_cnt); end
    checks++;
    if (baddr_q.size() != 1) begin errors++; $display("FAIL short_nbursts got %0d want 1", baddr_q.size()); end
    else begin
      checks++;
      if (baddr_q[0] !== 27'h2 || bc_q[0] !== 8'd3) begin
        errors++; $display("FAIL short_burst got %0h/%0d want 2/3", baddr_q[0], bc_q[0]);
      end
    end
    checks++;
    if (beat_q.size() != 3) begin errors++; $display("FAIL short_nbeats got %0d want 3", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 3; k++) begin
      checks++;
      if (beat_q[k] !== pair(2, k)) begin
        errors++; $display("FAIL short_beat%0d got %h want %h", k, beat_q[k], pair(2, k));
      end
    end
  endtask

  task automatic test_zero();
    clear();
    launch(32'h100, 32'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done got %b/%b want 1/0", done, busy);
    end
    @(posedge CLOCK); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", done); end
    repeat (3) @(posedge CLOCK);
    #1;
    checks++;
    if (beat_q.size() != 0 || baddr_q.size() != 0) begin
      errors++; $display("FAIL zero_write got %0d/%0d want 0/0", beat_q.size(), baddr_q.size());
    end
  endtask

  task automatic test_overflow();
    clear();
    wr_mode = 2;
    launch(32'h0, 32'd4096);
    feed(4, 0, 128);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
    feed(4, 128, 2);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++;
    if (sdram_write !== 1'b1 || beat_q.size() != 0) begin
      errors++; $display("FAIL ovf_stalled got %b/%0d want 1/0", sdram_write, beat_q.size());
    end
    feed(4, 130, 30);
    wr_mode = 0;
    repeat (200) @(negedge CLOCK);
    #2;
    checks++;
    if (beat_q.size() != 64) begin errors++; $display("FAIL ovf_nbeats got %0d want 64", beat_q.size()); end
    for (int k = 0; k < beat_q.size() && k < 64; k++) begin
      checks++;
      if (beat_q[k] !== pair(4, k)) begin
        errors++; $display("FAIL ovf_beat%0d got %h want %h", k, beat_q[k], pair(4, k));
      end
    end
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b/%b want 1/1", overflow, busy);
    end
    reset_n = 0;
    @(posedge CLOCK); #1;
    reset_n = 1;
  endtask

  task automatic test_async_reset();
    int n = 0;
    clear();
    wr_mode = 2;
    launch(32'h0, 32'd1024);
    feed(5, 0, 64);
    wr_mode = 0;
    while (beat_q.size() < 5 && n < 100) begin
      @(negedge CLOCK); #2;
      n++;
    end
    checks++;
    if (beat_q.size() != 5 || sdram_write !== 1'b1) begin
      errors++; $display("FAIL arst_fifth_beat got %0d/%b want 5/1", beat_q.size(), sdram_write);
    end
    reset_n = 0;
    #1;
    checks++;
    if (sdram_write !== 1'b0 || busy !== 1'b0 || sdram_address !== 27'd0) begin
      errors++; $display("FAIL arst_immediate got %b/%b/%0h want 0/0/0", sdram_write, busy, sdram_address);
    end
    @(posedge CLOCK); #1;
    reset_n = 1;
    clear();
    launch(32'h200, 32'd32);
    feed(5, 100, 2);
    wait_done(100);
    checks++;
    if (done_cnt != 1 || overflow !== 1'b0) begin
      errors++; $display("FAIL arst_rerun got %0d/%b want 1/0", done_cnt, overflow);
    end
    checks++;
    if (beat_q.size() != 1 || baddr_q.size() != 1) begin
      errors++; $display("FAIL arst_rerun_count got %0d/%0d want 1/1", beat_q.size(), baddr_q.size());
    end
    else begin
      checks++;
      if (beat_q[0] !== pair(5, 50) || baddr_q[0] !== 27'h10 || bc_q[0] !== 8'd1) begin
        errors++; $display("FAIL arst_rerun_beat got %0h/%0d %h want 10/1 %h", baddr_q[0], bc_q[0], beat_q[0], pair(5, 50));
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_short();
    test_stall();
    test_zero();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
